// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule generator: 16-word sliding window emitting W0..W(ROUNDS-1) over valid/ready.
// Optional macro SHA256_KT_EN adds kt_data, the round constant K[w_index] aligned with w_data.
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [5:0]   w_index,
  output logic         w_last
`ifdef SHA256_KT_EN
  ,
  output logic [31:0]  kt_data
`endif
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_e      state_q, state_d;
  logic [31:0] window_q [16];
  logic [31:0] window_d [16];
  logic [5:0]  t_q, t_d;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    t_d      = t_q;
    case (state_q)
      IDLE: begin
        if (blk_valid) begin
          for (int i = 0; i < 16; i++) window_d[i] = blk_data[511 - 32*i -: 32];
          t_d     = 6'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (w_ready) begin
          // The new tail word is W(t+16), ready long before it reaches window[0].
          for (int i = 0; i < 15; i++) window_d[i] = window_q[i+1];
          window_d[15] = sig1(window_q[14]) + window_q[9] + sig0(window_q[1]) + window_q[0];
          if (t_q == LAST_T) begin
            t_d     = 6'd0;
            state_d = IDLE;
          end else begin
            t_d = t_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      window_q <= '{default: 32'd0};
      t_q      <= 6'd0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      t_q      <= t_d;
    end
  end

  // All outputs come straight from registers; w_ready only affects the next state.
  assign blk_ready = (state_q == IDLE);
  assign w_valid   = (state_q == RUN);
  assign w_data    = window_q[0];
  assign w_index   = t_q;
  assign w_last    = w_valid && (t_q == LAST_T);

`ifdef SHA256_KT_EN
  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Zero outside RUN so the output matches its reset value while idle.
  assign kt_data = w_valid ? K_ROM[t_q] : 32'd0;
`endif

endmodule
